// File: rtl/grid_pkg.sv
// Shared definitions for the 4x4 stencil grid run controller: geometry, init sources and FSM states.
`timescale 1ns/1ps
package grid_pkg;
    localparam int GRID_N = 4;
    localparam int CELLS  = GRID_N * GRID_N;
    localparam int CELL_W = 8;

    localparam logic [3:0] CENTRE_0 = 4'd5;
    localparam logic [3:0] CENTRE_1 = 4'd6;
    localparam logic [3:0] CENTRE_2 = 4'd9;
    localparam logic [3:0] CENTRE_3 = 4'd10;

    localparam logic [1:0] SEL_ZERO   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_LOAD   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_STEP,
        ST_SETTLE,
        ST_READ,
        ST_DONE
    } state_t;

    function automatic logic is_centre(input logic [3:0] addr);
        return (addr == CENTRE_0) || (addr == CENTRE_1) ||
               (addr == CENTRE_2) || (addr == CENTRE_3);
    endfunction
endpackage

// File: rtl/grid_preset_rom.sv
// Initial cell value for the zero and semi-Gaussian sources; external loads bypass this table.
`timescale 1ns/1ps
module grid_preset_rom
    import grid_pkg::*;
#(
    parameter int           W    = CELL_W,
    parameter logic [W-1:0] PEAK = 8'h10
) (
    input  logic [3:0]   addr,
    input  logic [1:0]   sel,
    output logic [W-1:0] data
);
    always_comb begin
        data = '0;
        if (sel == SEL_PRESET && is_centre(addr)) begin
            data = PEAK;
        end
    end
endmodule

// File: rtl/grid_sim_sequencer.sv
// Run controller: initialises the grid, pulses the update datapath ITER times, then streams the
// 16 cells out over a valid/ready port.
`timescale 1ns/1ps
module grid_sim_sequencer
    import grid_pkg::*;
#(
    parameter int           W      = CELL_W,
    parameter logic [W-1:0] PEAK   = 8'h10,
    parameter int           SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   init_sel,
    input  logic [7:0]   iter_count,
    input  logic         ld_valid,
    input  logic [W-1:0] ld_data,
    output logic         ld_ready,
    output logic         init_we,
    output logic [3:0]   init_addr,
    output logic [W-1:0] init_data,
    output logic         step_en,
    output logic [3:0]   rd_addr,
    input  logic [W-1:0] rd_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [7:0]   steps_done
);
    localparam logic [3:0] LAST_CELL   = 4'(CELLS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t       state_q, state_d;
    logic [1:0]   sel_q, sel_d;
    logic [7:0]   iter_q, iter_d;
    logic [7:0]   steps_q, steps_d;
    logic [3:0]   cell_q, cell_d;
    logic [3:0]   rd_addr_q, rd_addr_d;
    logic [3:0]   settle_q, settle_d;
    logic [W-1:0] preset_data;

    grid_preset_rom #(.W(W), .PEAK(PEAK)) u_preset_rom (
        .addr (cell_q),
        .sel  (sel_q),
        .data (preset_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_ZERO;
            iter_q    <= '0;
            steps_q   <= '0;
            cell_q    <= '0;
            rd_addr_q <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            iter_q    <= iter_d;
            steps_q   <= steps_d;
            cell_q    <= cell_d;
            rd_addr_q <= rd_addr_d;
            settle_q  <= settle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        iter_d    = iter_q;
        steps_d   = steps_q;
        cell_d    = cell_q;
        rd_addr_d = rd_addr_q;
        settle_d  = settle_q;
        ld_ready  = 1'b0;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;
        step_en   = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // The reserved source code behaves exactly like zeros.
                    sel_d     = (init_sel == 2'd3) ? SEL_ZERO : init_sel;
                    iter_d    = iter_count;
                    steps_d   = '0;
                    cell_d    = '0;
                    rd_addr_d = '0;
                    state_d   = ST_INIT;
                end
            end
            ST_INIT: begin
                init_addr = cell_q;
                if (sel_q == SEL_LOAD) begin
                    ld_ready  = 1'b1;
                    init_we   = ld_valid;
                    init_data = ld_data;
                end else begin
                    init_we   = 1'b1;
                    init_data = preset_data;
                end
                if (init_we) begin
                    cell_d = cell_q + 4'd1;
                    if (cell_q == LAST_CELL) begin
                        state_d = (iter_q != '0) ? ST_STEP : ST_READ;
                    end
                end
            end
            ST_STEP: begin
                step_en  = 1'b1;
                steps_d  = steps_q + 8'd1;
                settle_d = '0;
                // Every pulse, including the final one, is followed by the settle gap.
                if (SETTLE != 0) begin
                    state_d = ST_SETTLE;
                end else if (steps_d == iter_q) begin
                    state_d = ST_READ;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = (steps_q == iter_q) ? ST_READ : ST_STEP;
                end
            end
            ST_READ: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rd_addr_d = rd_addr_q + 4'd1;
                    if (rd_addr_q == LAST_CELL) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_addr    = rd_addr_q;
    assign out_data   = out_valid ? rd_data : '0;
    assign steps_done = steps_q;
endmodule

// File: tb/tb_grid_sim_sequencer.sv
// Self-checking bench for grid_sim_sequencer: a run-level model checked every cycle, plus hand-computed pins.
`timescale 1ns/1ps
module tb_grid_sim_sequencer;
    localparam int SETTLE = 2;
    localparam int PERIOD = SETTLE + 1;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic [1:0] initSel   = 2'd0;
    logic [7:0] iterCount = 8'd0;
    logic       ldValid   = 1'b0;
    logic [7:0] ldData    = 8'd0;
    logic       outReady  = 1'b1;
    logic       ldReady, initWe, stepEn, outValid, busy, done;
    logic [3:0] initAddr, rdAddr;
    logic [7:0] initData, rdData, outData, stepsDone;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grid_sim_sequencer #(.W(8), .PEAK(8'h10), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .init_sel   (initSel),
        .iter_count (iterCount),
        .ld_valid   (ldValid),
        .ld_data    (ldData),
        .ld_ready   (ldReady),
        .init_we    (initWe),
        .init_addr  (initAddr),
        .init_data  (initData),
        .step_en    (stepEn),
        .rd_addr    (rdAddr),
        .rd_data    (rdData),
        .out_valid  (outValid),
        .out_data   (outData),
        .out_ready  (outReady),
        .busy       (busy),
        .done       (done),
        .steps_done (stepsDone)
    );

    // Stand-in grid and datapath: every step adds one to every cell.
    logic [7:0] grid [16];
    assign rdData = grid[rdAddr];
    always @(posedge clk) begin
        if (initWe) grid[initAddr] <= initData;
        else if (stepEn) for (int i = 0; i < 16; i++) grid[i] <= grid[i] + 8'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Semi-Gaussian preset: the inner 2x2 block of the 4x4 grid holds the peak.
    function automatic logic [7:0] presetValue(input int a);
        int row, col;
        row = a / 4;
        col = a % 4;
        return (row >= 1 && row <= 2 && col >= 1 && col <= 2) ? 8'h10 : 8'h00;
    endfunction

    // Run-level model: phase of the run plus counts of writes, step cycles and reads.
    typedef enum int {M_IDLE, M_INIT, M_STEPS, M_READ, M_DONE} phase_t;
    phase_t     mPhase = M_IDLE;
    int         mWr = 0, mRd = 0, mCyc = 0, mIter = 0;
    logic [1:0] mSel = 2'd0;
    logic [7:0] mSteps = 8'd0;
    logic [7:0] mInit [16];

    always @(negedge clk) begin
        logic [7:0] expData;
        checkOutput("busy", busy, mPhase != M_IDLE);
        checkOutput("done", done, mPhase == M_DONE);
        checkOutput("steps_done", stepsDone, mSteps);
        checkOutput("ld_ready", ldReady, mPhase == M_INIT && mSel == 2'd2);
        if (mPhase == M_INIT) begin
            if (mSel == 2'd2) begin
                checkOutput("init_we", initWe, ldValid);
                expData = ldData;
            end else begin
                checkOutput("init_we", initWe, 1'b1);
                expData = (mSel == 2'd1) ? presetValue(mWr) : 8'h00;
            end
            if (initWe) begin
                checkOutput("init_addr", initAddr, mWr);
                checkOutput("init_data", initData, expData);
            end
        end else begin
            checkOutput("init_we", initWe, 1'b0);
        end
        checkOutput("step_en", stepEn, mPhase == M_STEPS && (mCyc % PERIOD) == 0);
        checkOutput("out_valid", outValid, mPhase == M_READ);
        if (mPhase == M_READ) begin
            checkOutput("rd_addr", rdAddr, mRd);
            checkOutput("out_data", outData, 8'(mInit[mRd] + mIter));
        end else begin
            checkOutput("out_data_idle", outData, 8'h00);
        end

        if (!rst_n) begin
            mPhase = M_IDLE;
            mSteps = 8'd0;
        end else begin
            case (mPhase)
                M_IDLE: if (start) begin
                    mSel   = (initSel == 2'd3) ? 2'd0 : initSel;
                    mIter  = int'(iterCount);
                    mSteps = 8'd0;
                    mWr    = 0;
                    mPhase = M_INIT;
                end
                M_INIT: if (mSel != 2'd2 || ldValid) begin
                    mInit[mWr] = (mSel == 2'd2) ? ldData : (mSel == 2'd1) ? presetValue(mWr) : 8'h00;
                    mWr++;
                    if (mWr == 16) begin
                        mCyc   = 0;
                        mRd    = 0;
                        mPhase = (mIter == 0) ? M_READ : M_STEPS;
                    end
                end
                M_STEPS: begin
                    if ((mCyc % PERIOD) == 0) mSteps++;
                    mCyc++;
                    if (mCyc == mIter * PERIOD) begin
                        mRd    = 0;
                        mPhase = M_READ;
                    end
                end
                M_READ: if (outReady) begin
                    mRd++;
                    if (mRd == 16) mPhase = M_DONE;
                end
                M_DONE: mPhase = M_IDLE;
                default: mPhase = M_IDLE;
            endcase
        end
    end

    // Event log used by the hand-computed pins.
    int cyc = 0;
    int doneCount = 0, stepCount = 0, lastWeCyc = 0, firstStepCyc = 0, prevStepCyc = 0;
    int stepGap = 0, addr7Cycles = 0;
    logic [7:0] wrLog [16];
    logic [7:0] readLog [16];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (initWe) begin
            wrLog[initAddr] = initData;
            lastWeCyc = cyc;
        end
        if (stepEn) begin
            if (stepCount == 0) firstStepCyc = cyc;
            else stepGap = cyc - prevStepCyc;
            prevStepCyc = cyc;
            stepCount++;
        end
        if (done) doneCount++;
        if (outValid && rdAddr == 4'd7) addr7Cycles++;
        if (outValid && outReady) readLog[rdAddr] = outData;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog;
        doneCount = 0;
        stepCount = 0;
        stepGap = 0;
        addr7Cycles = 0;
    endtask

    task automatic feedLoad;
        int idx = 0;
        int guard = 0;
        bit phase = 1'b1;
        while (idx < 16 && guard < 200) begin
            if (ldReady && phase) begin
                ldValid = 1'b1;
                ldData  = 8'h30 + 8'(idx * 7);
            end else begin
                ldValid = 1'b0;
            end
            tick;
            if (ldValid) idx++;
            phase = !phase;
            guard++;
        end
        ldValid = 1'b0;
        if (idx < 16) checkOutput("load_timeout", idx, 16);
    endtask

    task automatic waitDone(input int stallAt, input int stallLen);
        int guard = 0;
        int stalled = 0;
        while (!done && guard < 3000) begin
            if (outValid && rdAddr == 4'(stallAt) && stalled < stallLen) begin
                outReady = 1'b0;
                stalled++;
            end else begin
                outReady = 1'b1;
            end
            tick;
            guard++;
        end
        if (!done) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] iter, input bit holdStart,
                                 input int stallAt, input int stallLen);
        clearLog();
        initSel   = sel;
        iterCount = iter;
        start     = 1'b1;
        tick;
        if (!holdStart) start = 1'b0;
        iterCount = 8'hEE;
        initSel   = 2'd0;
        if (sel == 2'd2) feedLoad();
        waitDone(stallAt, stallLen);
        tick;
        start    = 1'b0;
        outReady = 1'b1;
        tick;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_steps", stepsDone, 8'd0);
        checkOutput("reset_rd_addr", rdAddr, 4'd0);
        checkOutput("reset_out_valid", outValid, 1'b0);

        $display("[TB] preset init, no steps");
        applyStimulus(2'd1, 8'd0, 1'b0, 0, 0);
        checkOutput("t1_wr0", wrLog[0], 8'h00);
        checkOutput("t1_wr5", wrLog[5], 8'h10);
        checkOutput("t1_wr10", wrLog[10], 8'h10);
        checkOutput("t1_wr15", wrLog[15], 8'h00);
        checkOutput("t1_steps", stepCount, 0);
        checkOutput("t1_read6", readLog[6], 8'h10);
        checkOutput("t1_read3", readLog[3], 8'h00);
        checkOutput("t1_done", doneCount, 1);

        $display("[TB] zero init, three steps");
        applyStimulus(2'd0, 8'd3, 1'b0, 0, 0);
        checkOutput("t2_steps", stepCount, 3);
        checkOutput("t2_gap", stepGap, 3);
        checkOutput("t2_first_step", firstStepCyc - lastWeCyc, 1);
        checkOutput("t2_steps_done", stepsDone, 8'd3);
        checkOutput("t2_read0", readLog[0], 8'h03);

        $display("[TB] external load with gaps");
        ldValid = 1'b1;
        ldData  = 8'h55;
        tick;
        ldValid = 1'b0;
        applyStimulus(2'd2, 8'd1, 1'b0, 0, 0);
        checkOutput("t3_wr0", wrLog[0], 8'h30);
        checkOutput("t3_wr15", wrLog[15], 8'h99);
        checkOutput("t3_read0", readLog[0], 8'h31);
        checkOutput("t3_read15", readLog[15], 8'h9A);

        $display("[TB] readout stall at addr 7");
        applyStimulus(2'd0, 8'd2, 1'b0, 7, 5);
        checkOutput("t4_addr7_cycles", addr7Cycles, 6);
        checkOutput("t4_read8", readLog[8], 8'h02);

        $display("[TB] reset during settle of step 2");
        clearLog();
        initSel   = 2'd0;
        iterCount = 8'd5;
        start     = 1'b1;
        tick;
        start = 1'b0;
        guard = 0;
        while (!(stepsDone == 8'd2 && !stepEn && busy) && guard < 500) begin
            tick;
            guard++;
        end
        if (guard >= 500) checkOutput("t5_reach_settle", 0, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_steps", stepsDone, 8'd0);
        checkOutput("t5_step_en", stepEn, 1'b0);
        tick;
        checkOutput("t5_no_done", doneCount, 0);
        applyStimulus(2'd1, 8'd1, 1'b0, 0, 0);
        checkOutput("t5_rerun_done", doneCount, 1);
        checkOutput("t5_rerun_read5", readLog[5], 8'h11);

        $display("[TB] start held through run and DONE");
        applyStimulus(2'd3, 8'd1, 1'b1, 0, 0);
        checkOutput("t6_done_once", doneCount, 1);
        checkOutput("t6_idle", busy, 1'b0);
        checkOutput("t6_read9", readLog[9], 8'h01);

        $display("[TB] iter_count 255");
        applyStimulus(2'd1, 8'd255, 1'b0, 0, 0);
        checkOutput("t7_steps_done", stepsDone, 8'd255);
        checkOutput("t7_read0", readLog[0], 8'hFF);
        checkOutput("t7_read5", readLog[5], 8'h0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
